// File: rtl/mux16_rr_sched_pkg.sv
// mux16_rr_sched_pkg: shared constants, state encoding and round-robin search for mux16_rr_sched
package mux16_rr_sched_pkg;
    localparam int NUM_REQ = 16;
    localparam int SEL_W = 4;
    localparam int DEF_QUANTUM = 4;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [SEL_W-1:0] base);
        logic [SEL_W-1:0] idx;
        rr_pick = base;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = base + SEL_W'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction
endpackage

// File: rtl/mux16_rr_sched_mux.sv
// mux_16to1: 16-lane single-bit data selector
module mux_16to1
    import mux16_rr_sched_pkg::*;
(
    output logic out,
    input logic [NUM_REQ-1:0] in,
    input logic [SEL_W-1:0] sel
);
    assign out = in[sel];
endmodule

// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: 16-way round-robin quantum scheduler with data mux; MUX16_SCHED_LOCK_EN adds a lock input
module mux16_rr_sched
    import mux16_rr_sched_pkg::*;
#(
    parameter int QUANTUM = DEF_QUANTUM
) (
    input logic clk,
    input logic rst_n,
    input logic [NUM_REQ-1:0] req,
    input logic [NUM_REQ-1:0] data_in,
`ifdef MUX16_SCHED_LOCK_EN
    input logic lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic valid,
    output logic mux_out
);
    localparam logic [7:0] CMAX = 8'(QUANTUM - 1);
    state_t st;
    logic [7:0] cnt;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] idle_pick;
    logic [SEL_W-1:0] hand_pick;
    logic [NUM_REQ-1:0] others;
    logic at_max;
    logic hold;
    logic rel;
    logic lane;
`ifdef MUX16_SCHED_LOCK_EN
    assign hold = lock & req[sel];
`else
    assign hold = 1'b0;
`endif
    always_comb begin
        at_max = cnt == CMAX;
        rel = !req[sel] || (at_max && !hold);
        others = req & ~(NUM_REQ'(1) << sel);
        idle_pick = rr_pick(req, last);
        hand_pick = rr_pick(others, sel);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st <= IDLE;
            gnt <= '0;
            sel <= '0;
            valid <= 1'b0;
            cnt <= '0;
            last <= 4'hF;
        end else if (st == IDLE) begin
            if (|req) begin
                st <= GRANT;
                sel <= idle_pick;
                gnt <= NUM_REQ'(1) << idle_pick;
                valid <= 1'b1;
                cnt <= '0;
            end
        end else if (!rel) begin
            cnt <= at_max ? cnt : cnt + 8'd1;
        end else begin
            // a sole requester hitting expiry falls through here and is re-granted with cnt cleared
            last <= sel;
            cnt <= '0;
            if (|others) begin
                sel <= hand_pick;
                gnt <= NUM_REQ'(1) << hand_pick;
            end else if (!req[sel]) begin
                st <= IDLE;
                valid <= 1'b0;
                gnt <= '0;
            end
        end
    end
    mux_16to1 u_mux (.out(lane), .in(data_in), .sel(sel));
    assign mux_out = lane & valid;
endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb_mux16_rr_sched: scoreboard bench comparing mux16_rr_sched against a cycle-level ownership model
module tb_mux16_rr_sched;
    localparam int Q = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] data_in = '0;
    logic [15:0] gnt;
    logic [3:0] sel;
    logic valid;
    logic mux_out;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    typedef struct {
        int due;
        logic [15:0] g;
        logic [3:0] s;
        logic v;
    } exp_t;
    exp_t q[$];
    bit m_act = 0;
    int m_own = 0;
    int m_held = 0;
    int m_last = 15;

    mux16_rr_sched #(.QUANTUM(Q)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .gnt(gnt), .sel(sel), .valid(valid), .mux_out(mux_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int first_from(input logic [15:0] r, input int base);
        for (int k = 1; k <= 16; k++) if (r[(base + k) % 16]) return (base + k) % 16;
        return -1;
    endfunction

    task automatic model_step(input logic [15:0] r, input logic rn);
        int nxt;
        if (!rn) begin
            m_act = 0; m_own = 0; m_held = 0; m_last = 15;
        end else if (!m_act) begin
            if (r != 0) begin
                m_own = first_from(r, m_last); m_act = 1; m_held = 1;
            end
        end else if (r[m_own] && m_held < Q) begin
            m_held++;
        end else begin
            m_last = m_own;
            nxt = first_from(r & ~(16'd1 << m_own), m_own);
            if (nxt >= 0) begin
                m_own = nxt; m_held = 1;
            end else if (r[m_own]) m_held = 1;
            else m_act = 0;
        end
    endtask

    task automatic cycle(input logic [15:0] r, input logic [15:0] d, input logic rn);
        exp_t e;
        @(posedge clk);
        #1;
        req = r; data_in = d; rst_n = rn;
        model_step(r, rn);
        e.due = cyc + 1;
        e.g = m_act ? 16'd1 << m_own : 16'd0;
        e.s = 4'(m_own);
        e.v = m_act;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("gnt", gnt, e.g);
                check("sel", 16'(sel), 16'(e.s));
                check("valid", 16'(valid), 16'(e.v));
                check("mux_out", 16'(mux_out), 16'(e.v & data_in[e.s]));
            end
        end
    end

    initial begin : stim
        logic [15:0] r;
        repeat (3) cycle(16'hFFFF, 16'h0000, 1'b0);
        repeat (10) cycle(16'h0001, 16'h0001, 1'b1);
        repeat (2) cycle(16'h0000, 16'h0000, 1'b1);
        cycle(16'h0000, 16'h0000, 1'b0);
        repeat (20) cycle(16'h8001, 16'h8000, 1'b1);
        cycle(16'h0000, 16'h0000, 1'b0);
        repeat (2) cycle(16'h0008, 16'h0008, 1'b1);
        repeat (2) cycle(16'h0108, 16'h0100, 1'b1);
        repeat (3) cycle(16'h0100, 16'h0100, 1'b1);
        cycle(16'h0000, 16'h0000, 1'b0);
        repeat (9) cycle(16'h0014, 16'hC3B4, 1'b1);
        repeat (3) cycle(16'h0000, 16'hC3B4, 1'b1);
        cycle(16'h0000, 16'h0000, 1'b0);
        repeat (6) cycle(16'h0020, 16'hFFFF, 1'b1);
        repeat (2) cycle(16'hFFFF, 16'hAAAA, 1'b1);
        cycle(16'hFFFF, 16'hAAAA, 1'b0);
        repeat (6) cycle(16'hFFFF, 16'h5555, 1'b1);
        for (int i = 0; i < 500; i++) begin
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 5) == 0) r = '0;
            cycle(r, 16'($urandom), $urandom_range(0, 60) != 0);
        end
        repeat (2) @(posedge clk);
        #3;
        check("drain", 16'(q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
